// File: rtl/vector_operand_packer_pkg.sv
// ---------------------------------------------------------------------------
// vector_operand_packer_pkg
//   Shared definitions for the vector operand packer: the float element
//   width, the encoding of a padded (zero) lane, the two FSM states and
//   small helpers that size the lane index and length fields from VLEN.
//   No ports; imported by the interface and the packer itself.
// ---------------------------------------------------------------------------
package vector_operand_packer_pkg;

   localparam int          FLOAT_W = 32;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } packerState_e;

   // Lane index width; VLEN=1 still needs a one-bit index register.
   function automatic int idxWidth(input int vlen);
      return (vlen > 1) ? $clog2(vlen) : 1;
   endfunction

   // Length field must be able to hold the value VLEN itself.
   function automatic int lenWidth(input int vlen);
      return $clog2(vlen + 1);
   endfunction

endpackage

// File: rtl/vector_operand_packer_if.sv
// ---------------------------------------------------------------------------
// vector_operand_packer_if
//   Bundles the input element stream and the packed output vector stream of
//   the vector operand packer.
//   Signals:
//     in_valid / in_ready   element pair handshake
//     in_a, in_b            one float32 element of A and of B
//     in_last               final pair of a short vector (zero-pad builds)
//     out_valid / out_ready packed vector handshake
//     out_a, out_b          packed vectors, element i in bits [32*i +: 32]
//     out_len               number of loaded elements
//   Modports:
//     master  producer/consumer side (drives in_*, out_ready)
//     slave   the packer (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface vector_operand_packer_if #(
   parameter int VLEN = 4
);
   import vector_operand_packer_pkg::*;

   localparam int CW = lenWidth(VLEN);

   logic                      in_valid;
   logic                      in_ready;
   logic [FLOAT_W-1:0]        in_a;
   logic [FLOAT_W-1:0]        in_b;
   logic                      in_last;
   logic                      out_valid;
   logic                      out_ready;
   logic [FLOAT_W*VLEN-1:0]   out_a;
   logic [FLOAT_W*VLEN-1:0]   out_b;
   logic [CW-1:0]             out_len;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_len
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_a, out_b, out_len
   );

endinterface

// File: rtl/vector_operand_packer.sv
// ---------------------------------------------------------------------------
// vector_operand_packer
//   Upstream feeder for the combinational dot-product stage. Collects one
//   (A,B) float32 pair per accepted beat into lane idx, and once VLEN lanes
//   are loaded presents the packed A/B vectors, held stable, until the
//   consumer takes them. Payload bits are never interpreted.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    vector_operand_packer_if.slave (element stream in, vector out)
//   Parameters:
//     VLEN   elements per vector (>= 1), must match the dot-product stage
//   Build option:
//     ZERO_PAD_EN  when defined, an accepted beat with in_last=1 ends the
//                  vector early and zero-fills the unused upper lanes.
//                  When undefined, in_last is ignored.
// ---------------------------------------------------------------------------
module vector_operand_packer
   import vector_operand_packer_pkg::*;
#(
   parameter int VLEN = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   vector_operand_packer_if.slave   bus
);

   localparam int             IW       = idxWidth(VLEN);
   localparam int             CW       = lenWidth(VLEN);
   localparam logic [IW-1:0]  LAST_IDX = IW'(VLEN - 1);

   packerState_e              state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [CW-1:0]             len_q, len_d;
   logic [FLOAT_W-1:0]        laneA_q [VLEN];
   logic [FLOAT_W-1:0]        laneA_d [VLEN];
   logic [FLOAT_W-1:0]        laneB_q [VLEN];
   logic [FLOAT_W-1:0]        laneB_d [VLEN];
   logic [VLEN-1:0]           laneSel;
   logic                      accept;
   logic [FLOAT_W*VLEN-1:0]   packA;
   logic [FLOAT_W*VLEN-1:0]   packB;

   // Handshake outputs depend only on the registered state, so there is
   // no combinational path from in_valid back to in_ready.
   assign bus.in_ready  = (state_q == ST_FILL);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign accept        = bus.in_valid && bus.in_ready;

`ifndef ZERO_PAD_EN
   // in_last has no meaning when short vectors are not supported.
   logic unusedLast;
   assign unusedLast = bus.in_last;
`endif

   // One-hot decode of the fill index into per-lane write enables.
   always_comb begin
      laneSel = '0;
      for (int i = 0; i < VLEN; i++) begin
         laneSel[i] = (idx_q == IW'(i));
      end
   end

   // Next-state logic. In FILL each accepted beat lands in the selected
   // lane; the beat into the last lane (or, with zero padding, a beat
   // flagged in_last) closes the vector and moves to HOLD. In HOLD nothing
   // changes until the consumer takes the vector. idx stays on the last
   // loaded lane during HOLD and is cleared on the take, so it never wraps.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      laneA_d = laneA_q;
      laneB_d = laneB_q;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               for (int i = 0; i < VLEN; i++) begin
                  if (laneSel[i]) begin
                     laneA_d[i] = bus.in_a;
                     laneB_d[i] = bus.in_b;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  state_d = ST_HOLD;
                  len_d   = CW'(VLEN);
               end
`ifdef ZERO_PAD_EN
               else if (bus.in_last) begin
                  for (int i = 0; i < VLEN; i++) begin
                     if (i > int'(idx_q)) begin
                        laneA_d[i] = FP_ZERO;
                        laneB_d[i] = FP_ZERO;
                     end
                  end
                  state_d = ST_HOLD;
                  len_d   = CW'(idx_q) + CW'(1);
               end
`endif
               else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_FILL;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = ST_FILL;
            idx_d   = '0;
         end
      endcase
   end

   // State and lane registers. Reset wins over any handshake in the same
   // cycle and discards a partially filled vector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_FILL;
         idx_q   <= '0;
         len_q   <= '0;
         for (int i = 0; i < VLEN; i++) begin
            laneA_q[i] <= FP_ZERO;
            laneB_q[i] <= FP_ZERO;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         laneA_q <= laneA_d;
         laneB_q <= laneB_d;
      end
   end

   // Flatten the lane registers into the packed output buses,
   // element 0 in the least significant word.
   always_comb begin
      packA = '0;
      packB = '0;
      for (int i = 0; i < VLEN; i++) begin
         packA[i*FLOAT_W +: FLOAT_W] = laneA_q[i];
         packB[i*FLOAT_W +: FLOAT_W] = laneB_q[i];
      end
   end

   assign bus.out_a   = packA;
   assign bus.out_b   = packB;
   assign bus.out_len = len_q;

endmodule
